// File: rtl/pc_sequencer_if.sv
// Bus bundle for pc_sequencer: control/datapath inputs and PC/RAS status outputs.
// slave  : the sequencer side
// master : the control FSM / datapath side driving it
interface pc_sequencer_if #(
   parameter int unsigned PC_W = 32
);
   logic            pc_write;
   logic            pc_write_cond;
   logic            zero;
   logic [1:0]      pc_src;
   logic [PC_W-1:0] alu_out;
   logic [PC_W-1:0] jump_tgt;
   logic            call;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_old;
   logic            ras_empty;
   logic            ras_full;
   logic            ras_ovf;
   logic            ras_unf;
   logic            misalign_err;

   modport slave (
      input  pc_write, pc_write_cond, zero, pc_src, alu_out, jump_tgt, call,
      output pc, pc_old, ras_empty, ras_full, ras_ovf, ras_unf, misalign_err
   );

   modport master (
      output pc_write, pc_write_cond, zero, pc_src, alu_out, jump_tgt, call,
      input  pc, pc_old, ras_empty, ras_full, ras_ovf, ras_unf, misalign_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC / pre-update PC registers, next-PC mux and a
// circular return-address stack (RAS) for call/return.
// Optional feature macro: PC_ALIGN_CHECK_EN -- suppresses updates to targets
// not aligned to STEP and raises a sticky misalign_err.
module pc_sequencer #(
   parameter int unsigned           PC_W      = 32,
   parameter logic [PC_W-1:0]       RESET_VEC = '0,
   parameter int unsigned           STEP      = 4,
   parameter int unsigned           RAS_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pc_sequencer_if.slave  bus
);

   localparam int unsigned         PTR_W    = $clog2(RAS_DEPTH);
   localparam int unsigned         CNT_W    = PTR_W + 1;
   localparam logic [PC_W-1:0]     STEP_V   = PC_W'(STEP);
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  old_q, old_d;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [PC_W-1:0]  wr_data;

   logic             upd, push, pop, empty, full, go, misalign;
   logic [PC_W-1:0]  pc_inc, nxt;

   assign upd   = bus.pc_write | (bus.pc_write_cond & bus.zero);
   assign push  = upd & bus.call;
   assign pop   = upd & (bus.pc_src == 2'b11);
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_FULL);

   // next-PC source mux; a pop on an empty stack falls back to sequential
   always_comb begin
      pc_inc = pc_q + STEP_V;
      nxt    = pc_inc;
      unique case (bus.pc_src)
         2'b00: nxt = pc_inc;
         2'b01: nxt = bus.alu_out;
         2'b10: nxt = bus.jump_tgt;
         2'b11: nxt = empty ? pc_inc : ras_q[top_q];
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);

   logic mis_q;
   logic sel_inc;

   // sequential increments never fault, only loaded targets are checked
   always_comb begin
      sel_inc  = (bus.pc_src == 2'b00) || ((bus.pc_src == 2'b11) && empty);
      misalign = upd && !sel_inc && ((nxt & ALIGN_MASK) != '0);
   end

   // sticky alignment trap flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mis_q <= 1'b0;
      else if (misalign) mis_q <= 1'b1;
   end

   assign bus.misalign_err = mis_q;
`else
   assign misalign         = 1'b0;
   assign bus.misalign_err = 1'b0;
`endif

   assign go = upd & ~misalign;

   // PC and RAS next-state; push+pop on a non-empty stack swaps the top entry
   // in place so count and pointer stay put
   always_comb begin
      pc_d    = pc_q;
      old_d   = old_q;
      top_d   = top_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = top_q;
      wr_data = pc_inc;
      if (go) begin
         pc_d  = nxt;
         old_d = pc_q;
         if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_q;
         end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PTR_W'(1);
            top_d  = top_q + PTR_W'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
         end else if (pop && !empty) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end
         if (pop && empty) unf_d = 1'b1;
      end
   end

   // state registers; reset discards the stack immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         old_q <= RESET_VEC;
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         old_q <= old_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         if (wr_en) ras_q[wr_idx] <= wr_data;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_old    = old_q;
   assign bus.ras_empty = empty;
   assign bus.ras_full  = full;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;

endmodule
